lattice_render: RTL and testbench

Display stage downstream of the lattice update engine. It reads the nine 8-bit distribution values per lattice cell from the lattice BRAM read port in raster order, driven by the video timing counters. From them it computes the macroscopic density and velocity, maps the selected quantity to 24-bit RGB, and emits pixels with delay-matched sync signals. It also pulses `frame_done_out` once per frame after the last lattice pixel, so the controller can step the simulation between frames without tearing.

---
 rtl/lattice_render.sv | 187 ++++++++++++++++++
 tb/tb_lattice_render.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_render.sv
// Converts lattice BRAM cells into RGB pixels with a fixed 6-cycle pipeline and delay-matched syncs.
// Optional macro LATTICE_BORDER_EN paints the outermost ring of lattice cells white.
module lattice_render #(
   parameter int LAT_W       = 205,
   parameter int LAT_H       = 154,
   parameter int SCALE_SHIFT = 2,
   parameter int BRAM_SIZE   = $clog2(LAT_W*LAT_H)
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [10:0]          hcount_in,
   input  logic [9:0]           vcount_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 active_draw_in,
   input  logic [1:0]           mode_in,
   input  logic [8:0][7:0]      bram_data_in,
   output logic [BRAM_SIZE-1:0] addr_out,
   output logic [7:0]           red_out,
   output logic [7:0]           green_out,
   output logic [7:0]           blue_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 active_draw_out,
   output logic                 frame_done_out
);

   localparam int DEPTH = 6;
   localparam logic [10:0] LAST_H = 11'((LAT_W << SCALE_SHIFT) - 1);
   localparam logic [9:0]  LAST_V = 10'((LAT_H << SCALE_SHIFT) - 1);

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       active;
      logic       in_lat;
      logic       last;
`ifdef LATTICE_BORDER_EN
      logic       border;
`endif
      logic [1:0] mode;
   } ctrl_t;

   function automatic logic [7:0] sat255(input logic [11:0] v);
      return (v > 12'd255) ? 8'hFF : v[7:0];
   endfunction

   // Stage 1: lattice coordinate, address and control capture
   logic [31:0]          lx, ly;
   logic                 in_lat;
   ctrl_t                ctrl_d;
   ctrl_t                ctrl_q [DEPTH];
   logic [BRAM_SIZE-1:0] addr_d, addr_q;
   logic                 armed_d, armed_q;

   always_comb begin
      lx     = 32'(hcount_in) >> SCALE_SHIFT;
      ly     = 32'(vcount_in) >> SCALE_SHIFT;
      in_lat = active_draw_in && (lx < LAT_W) && (ly < LAT_H);
      addr_d = in_lat ? BRAM_SIZE'(ly * LAT_W + lx) : '0;
      // A frame only counts once its first pixel has been seen since reset.
      armed_d = armed_q | ((hcount_in == '0) && (vcount_in == '0));
      ctrl_d        = '0;
      ctrl_d.hsync  = hsync_in;
      ctrl_d.vsync  = vsync_in;
      ctrl_d.active = active_draw_in;
      ctrl_d.in_lat = in_lat;
      ctrl_d.last   = armed_q && in_lat && (hcount_in == LAST_H) && (vcount_in == LAST_V);
`ifdef LATTICE_BORDER_EN
      ctrl_d.border = in_lat && ((lx == 0) || (lx == LAT_W - 1) || (ly == 0) || (ly == LAT_H - 1));
`endif
      ctrl_d.mode   = mode_in;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         addr_q  <= '0;
         armed_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= '0;
      end else begin
         addr_q    <= addr_d;
         armed_q   <= armed_d;
         ctrl_q[0] <= ctrl_d;
         for (int i = 1; i < DEPTH; i++) ctrl_q[i] <= ctrl_q[i-1];
      end
   end

   // Stage 4: directional partial sums (BRAM order C,N,NE,E,SE,S,SW,W,NW)
   logic [9:0] pe_d, pw_d, pn_d, ps_d, pc_d;
   logic [9:0] pe_q, pw_q, pn_q, ps_q, pc_q;
   logic [7:0] c4_d, c4_q;

   always_comb begin
      pe_d = 10'(bram_data_in[2]) + 10'(bram_data_in[3]) + 10'(bram_data_in[4]);
      pw_d = 10'(bram_data_in[8]) + 10'(bram_data_in[7]) + 10'(bram_data_in[6]);
      pn_d = 10'(bram_data_in[1]) + 10'(bram_data_in[2]) + 10'(bram_data_in[8]);
      ps_d = 10'(bram_data_in[5]) + 10'(bram_data_in[4]) + 10'(bram_data_in[6]);
      pc_d = 10'(bram_data_in[0]) + 10'(bram_data_in[1]) + 10'(bram_data_in[5]);
      c4_d = bram_data_in[0];
   end

   // Stage 5: density, x velocity and L1 speed
   logic [11:0]        rho_d, rho_q;
   logic signed [10:0] ux_d, uy_d, ux_q;
   logic [10:0]        ux_abs, uy_abs, spd_d, spd_q;
   logic [7:0]         c5_d, c5_q;

   always_comb begin
      rho_d  = 12'(pe_q) + 12'(pw_q) + 12'(pc_q);
      ux_d   = $signed({1'b0, pe_q}) - $signed({1'b0, pw_q});
      uy_d   = $signed({1'b0, pn_q}) - $signed({1'b0, ps_q});
      ux_abs = ux_d[10] ? 11'(-ux_d) : 11'(ux_d);
      uy_abs = uy_d[10] ? 11'(-uy_d) : 11'(uy_d);
      spd_d  = ux_abs + uy_abs;
      c5_d   = c4_q;
   end

   // Stage 6: colour mapping
   logic [23:0] rgb_d, rgb_q;
   logic [10:0] ux_neg;
   logic [7:0]  gray;

   always_comb begin
      rgb_d  = '0;
      ux_neg = 11'(-ux_q);
      gray   = sat255(rho_q >> 3);
      if (!ctrl_q[4].active) begin
         rgb_d = 24'h000000;
      end else if (!ctrl_q[4].in_lat) begin
         rgb_d = 24'h202020;
      end else begin
`ifdef LATTICE_BORDER_EN
         if (ctrl_q[4].border) begin
            rgb_d = 24'hFFFFFF;
         end else begin
`else
         begin
`endif
            case (ctrl_q[4].mode)
               2'd0:    rgb_d = {gray, gray, gray};
               2'd1:    rgb_d = {8'h00, sat255({1'b0, spd_q}), 8'h00};
               2'd2:    rgb_d = ux_q[10] ? {16'h0000, sat255({1'b0, ux_neg})}
                                         : {sat255({1'b0, ux_q}), 16'h0000};
               default: rgb_d = {c5_q, c5_q, c5_q};
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         pe_q  <= '0;
         pw_q  <= '0;
         pn_q  <= '0;
         ps_q  <= '0;
         pc_q  <= '0;
         c4_q  <= '0;
         rho_q <= '0;
         ux_q  <= '0;
         spd_q <= '0;
         c5_q  <= '0;
         rgb_q <= '0;
      end else begin
         pe_q  <= pe_d;
         pw_q  <= pw_d;
         pn_q  <= pn_d;
         ps_q  <= ps_d;
         pc_q  <= pc_d;
         c4_q  <= c4_d;
         rho_q <= rho_d;
         ux_q  <= ux_d;
         spd_q <= spd_d;
         c5_q  <= c5_d;
         rgb_q <= rgb_d;
      end
   end

   assign addr_out        = addr_q;
   assign red_out         = rgb_q[23:16];
   assign green_out       = rgb_q[15:8];
   assign blue_out        = rgb_q[7:0];
   assign hsync_out       = ctrl_q[DEPTH-1].hsync;
   assign vsync_out       = ctrl_q[DEPTH-1].vsync;
   assign active_draw_out = ctrl_q[DEPTH-1].active;
   assign frame_done_out  = ctrl_q[DEPTH-1].last;

endmodule

// File: tb/tb_lattice_render.sv
// Directed bench for lattice_render: vector table for colour/address mapping plus
// sequences for reset, latency, frame_done and reset mid-frame.
module tb_lattice_render;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic [10:0]      hcount_in;
   logic [9:0]       vcount_in;
   logic             hsync_in, vsync_in, active_draw_in;
   logic [1:0]       mode_in;
   logic [8:0][7:0]  bram_data_in;
   logic [14:0]      addr_out;
   logic [7:0]       red_out, green_out, blue_out;
   logic             hsync_out, vsync_out, active_draw_out, frame_done_out;

   lattice_render dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .active_draw_in(active_draw_in),
      .mode_in(mode_in), .bram_data_in(bram_data_in), .addr_out(addr_out),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .active_draw_out(active_draw_out),
      .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;

`ifdef LATTICE_BORDER_EN
   localparam logic [23:0] BORDER_RGB = 24'hFFFFFF;
`else
   localparam logic [23:0] BORDER_RGB = 24'h000000;
`endif

   typedef struct {
      logic [10:0]     hc;
      logic [9:0]      vc;
      logic            act;
      logic [1:0]      mode;
      logic [71:0]     data;
      logic [23:0]     rgb;
      logic [14:0]     addr;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulses = 0;
   int pulse_cyc = -1;
   int exp_pulse_cyc = -1;

   function automatic logic [71:0] mk(input int c, input int n, input int ne, input int e,
                                      input int se, input int s, input int sw, input int w,
                                      input int nw);
      return {8'(nw), 8'(w), 8'(sw), 8'(s), 8'(se), 8'(e), 8'(ne), 8'(n), 8'(c)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      if (frame_done_out) begin
         pulses++;
         pulse_cyc = cyc;
      end
   endtask

   function automatic logic [23:0] rgb();
      return {red_out, green_out, blue_out};
   endfunction

   task automatic drive(input int hc, input int vc, input logic act);
      hcount_in      = 11'(hc);
      vcount_in      = 10'(vc);
      active_draw_in = act;
   endtask

   task automatic run_row(input int vc, input int hc_max);
      for (int hc = 0; hc < hc_max; hc++) begin
         drive(hc, vc, 1'b1);
         if (vc == 615 && hc == 819) exp_pulse_cyc = cyc + 6;
         tick();
      end
   endtask

   task automatic flush();
      drive(0, 700, 1'b0);
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic arm();
      drive(0, 0, 1'b1);
      tick();
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{11'd8,   10'd4,   1'b1, 2'd0, mk(10,10,10,10,10,10,10,10,10),      24'h0B0B0B, 15'd207};
      vecs[1]  = '{11'd8,   10'd4,   1'b1, 2'd0, mk(127,127,127,127,127,127,127,127,127), 24'h8E8E8E, 15'd207};
      vecs[2]  = '{11'd8,   10'd4,   1'b1, 2'd0, mk(255,255,255,255,255,255,255,255,255), 24'hFFFFFF, 15'd207};
      vecs[3]  = '{11'd8,   10'd4,   1'b1, 2'd0, mk(8,0,0,0,0,0,0,0,0),               24'h010101, 15'd207};
      vecs[4]  = '{11'd8,   10'd4,   1'b1, 2'd2, mk(0,0,0,100,0,0,0,0,0),             24'h640000, 15'd207};
      vecs[5]  = '{11'd8,   10'd4,   1'b1, 2'd2, mk(0,0,0,0,0,0,127,127,127),         24'h0000FF, 15'd207};
      vecs[6]  = '{11'd8,   10'd4,   1'b1, 2'd2, mk(0,0,255,255,255,0,0,0,0),         24'hFF0000, 15'd207};
      vecs[7]  = '{11'd12,  10'd8,   1'b1, 2'd1, mk(0,50,20,0,0,0,0,0,0),             24'h005A00, 15'd413};
      vecs[8]  = '{11'd12,  10'd8,   1'b1, 2'd1, mk(0,200,200,0,0,0,0,0,200),         24'h00FF00, 15'd413};
      vecs[9]  = '{11'd12,  10'd8,   1'b1, 2'd3, mk(55,5,5,5,5,5,5,5,5),              24'h373737, 15'd413};
      vecs[10] = '{11'd820, 10'd4,   1'b1, 2'd0, mk(10,10,10,10,10,10,10,10,10),      24'h202020, 15'd0};
      vecs[11] = '{11'd8,   10'd616, 1'b1, 2'd0, mk(10,10,10,10,10,10,10,10,10),      24'h202020, 15'd0};
      vecs[12] = '{11'd8,   10'd4,   1'b0, 2'd0, mk(10,10,10,10,10,10,10,10,10),      24'h000000, 15'd0};
      vecs[13] = '{11'd0,   10'd148, 1'b1, 2'd1, mk(0,0,0,0,0,0,0,0,0),               BORDER_RGB, 15'd7585};
      vecs[14] = '{11'd4,   10'd148, 1'b1, 2'd1, mk(0,0,0,0,0,0,0,0,0),               24'h000000, 15'd7586};

      // Reset held with counters running and syncs high.
      rst_n_in = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      mode_in  = 2'd0;
      bram_data_in = mk(10,10,10,10,10,10,10,10,10);
      drive(8, 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rst%0d_rgb", i), 32'(rgb()), 32'h0);
         check($sformatf("rst%0d_addr", i), 32'(addr_out), 32'h0);
         check($sformatf("rst%0d_sync", i), {29'b0, hsync_out, vsync_out, active_draw_out}, 32'h0);
         check($sformatf("rst%0d_done", i), 32'(frame_done_out), 32'h0);
      end
      rst_n_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k < 6) begin
            check($sformatf("rel%0d_rgb", k), 32'(rgb()), 32'h0);
            check($sformatf("rel%0d_hsync", k), 32'(hsync_out), 32'h0);
         end else begin
            check("rel6_rgb", 32'(rgb()), 32'h0B0B0B);
            check("rel6_sync", {30'b0, hsync_out, vsync_out}, 32'h3);
         end
      end
      $display("reset sequence: rgb=%h after release", rgb());
      hsync_in = 1'b0;
      vsync_in = 1'b0;

      // Single-cycle pixel into a grey background: address at +1, pixel and sync at +6.
      drive(820, 4, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      drive(8, 4, 1'b1);
      hsync_in = 1'b1;
      tick();
      check("lat_addr1", 32'(addr_out), 32'd207);
      drive(820, 4, 1'b1);
      hsync_in = 1'b0;
      for (int k = 2; k <= 7; k++) begin
         tick();
         if (k == 2) check("lat_addr2", 32'(addr_out), 32'd0);
         if (k == 6) begin
            check("lat6_rgb", 32'(rgb()), 32'h0B0B0B);
            check("lat6_hsync", 32'(hsync_out), 32'h1);
         end else begin
            check($sformatf("lat%0d_rgb", k), 32'(rgb()), 32'h202020);
            check($sformatf("lat%0d_hsync", k), 32'(hsync_out), 32'h0);
         end
      end
      $display("latency sequence: done");

      for (int i = 0; i < 15; i++) begin
         drive(int'(vecs[i].hc), int'(vecs[i].vc), vecs[i].act);
         mode_in      = vecs[i].mode;
         bram_data_in = vecs[i].data;
         for (int k = 0; k < 7; k++) tick();
         check($sformatf("vec%0d_rgb", i), 32'(rgb()), 32'(vecs[i].rgb));
         check($sformatf("vec%0d_addr", i), 32'(addr_out), 32'(vecs[i].addr));
         check($sformatf("vec%0d_act", i), 32'(active_draw_out), 32'(vecs[i].act));
         $display("vec %0d: hc=%0d vc=%0d mode=%0d rgb=%h addr=%0d", i, vecs[i].hc, vecs[i].vc,
                  vecs[i].mode, rgb(), addr_out);
      end

      // Frame done for a frame that began at (0,0).
      mode_in = 2'd0;
      bram_data_in = mk(0,0,0,0,0,0,0,0,0);
      flush();
      pulses = 0;
      arm();
      run_row(614, 1280);
      run_row(615, 1280);
      run_row(616, 1280);
      flush();
      check("frame_pulses", 32'(pulses), 32'd1);
      check("frame_pulse_cyc", 32'(pulse_cyc), 32'(exp_pulse_cyc));
      $display("frame: pulses=%0d at cycle %0d", pulses, pulse_cyc);

      // Reset mid-frame suppresses that frame's pulse.
      pulses = 0;
      arm();
      run_row(300, 100);
      rst_n_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n_in = 1'b1;
      run_row(614, 1280);
      run_row(615, 1280);
      run_row(616, 1280);
      flush();
      check("midrst_pulses", 32'(pulses), 32'd0);
      $display("reset mid-frame: pulses=%0d", pulses);

      // Next complete frame pulses again.
      pulses = 0;
      arm();
      run_row(615, 1280);
      flush();
      check("next_pulses", 32'(pulses), 32'd1);
      check("next_pulse_cyc", 32'(pulse_cyc), 32'(exp_pulse_cyc));
      $display("next frame: pulses=%0d at cycle %0d", pulses, pulse_cyc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
